// File: rtl/press_sequencer.sv
// Single-button press sequencer: debounces a push-button, times each press in
// ticks, classifies it as short or long, and emits up to MAX_LEN elements per symbol.
module press_sequencer #(
  parameter int TICK_DIV   = 6510,
  parameter int DEB_CYCLES = 250000,
  parameter int SHORT_MAX  = 3840,
  parameter int LONG_MIN   = 4800,
  parameter int GAP_TICKS  = 7680,
  parameter int MAX_LEN    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic [4:0] sym_bits,
  output logic [2:0] sym_len,
  output logic       sym_err,
  output logic       elem_short,
  output logic       elem_long,
  output logic       btn_db
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [13:0]   SHORT_C   = 14'(SHORT_MAX);
  localparam logic [13:0]   LONG_C    = 14'(LONG_MIN);
  localparam logic [13:0]   GAP_C     = 14'(GAP_TICKS);
  localparam logic [13:0]   CNT_MAX   = 14'h3FFF;
  localparam logic [2:0]    MAX_LEN_C = 3'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;
  typedef enum logic [1:0] {CLS_SHORT, CLS_LONG, CLS_AMB} cls_t;

  state_t        state, state_nxt;
  logic          sync0, sync1;
  logic [DW-1:0] deb_cnt;
  logic          btn_prev;
  logic [PW-1:0] pre_cnt;
  logic [13:0]   dur;
  logic [13:0]   gap_cnt;
  logic [2:0]    len;
  logic [4:0]    bits;
  logic          err;

  logic db_rise, db_fall, tick;
  logic clr_dur, clr_gap, do_short, do_long, set_err, accept;
  cls_t cls;

  function automatic cls_t classify(input logic [13:0] d);
    if (d <= SHORT_C)
      return CLS_SHORT;
    else if (d >= LONG_C)
      return CLS_LONG;
    else
      return CLS_AMB;
  endfunction

  // Synchronizer and debouncer; any sample matching btn_db restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      sync0    <= button;
      sync1    <= sync0;
      btn_prev <= btn_db;
      if (sync1 == btn_db)
        deb_cnt <= '0;
      else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        btn_db  <= sync1;
      end else
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign db_rise = btn_db & ~btn_prev;
  assign db_fall = ~btn_db & btn_prev;

  // Prescaler restarts on every debounced edge so timing is phase-aligned to it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pre_cnt <= '0;
    else if (db_rise || db_fall || pre_cnt == TICK_LAST)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == TICK_LAST) && !(db_rise || db_fall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_dur   = 1'b0;
    clr_gap   = 1'b0;
    do_short  = 1'b0;
    do_long   = 1'b0;
    set_err   = 1'b0;
    accept    = 1'b0;
    cls       = classify(dur);
    case (state)
      IDLE: begin
        if (db_rise) begin
          state_nxt = PRESS;
          clr_dur   = 1'b1;
        end
      end
      PRESS: begin
        if (db_fall) begin
          state_nxt = GAP;
          clr_gap   = 1'b1;
          case (cls)
            CLS_SHORT: do_short = 1'b1;
            CLS_LONG:  do_long  = 1'b1;
            default:   set_err  = 1'b1;
          endcase
        end
      end
      GAP: begin
        // An expired gap wins over a simultaneous new press
        if (gap_cnt >= GAP_C)
          state_nxt = (len != 3'd0 || err) ? EMIT : IDLE;
        else if (db_rise) begin
          state_nxt = PRESS;
          clr_dur   = 1'b1;
        end
      end
      EMIT: begin
        if (sym_ready) begin
          state_nxt = IDLE;
          accept    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dur        <= '0;
      gap_cnt    <= '0;
      len        <= '0;
      bits       <= '0;
      err        <= 1'b0;
      elem_short <= 1'b0;
      elem_long  <= 1'b0;
    end else begin
      elem_short <= do_short;
      elem_long  <= do_long;

      if (clr_dur)
        dur <= '0;
      else if (state == PRESS && tick && dur != CNT_MAX)
        dur <= dur + 14'd1;

      if (clr_gap)
        gap_cnt <= '0;
      else if (state == GAP && tick && gap_cnt != CNT_MAX)
        gap_cnt <= gap_cnt + 14'd1;

      if (accept) begin
        len  <= '0;
        bits <= '0;
        err  <= 1'b0;
      end else begin
        if (do_short || do_long) begin
          if (len == MAX_LEN_C)
            err <= 1'b1;
          else begin
            bits <= bits | (5'(do_long) << len);
            len  <= len + 3'd1;
          end
        end
        if (set_err)
          err <= 1'b1;
      end
    end
  end

  assign sym_valid = (state == EMIT);
  assign sym_bits  = sym_valid ? bits : 5'd0;
  assign sym_len   = sym_valid ? len  : 3'd0;
  assign sym_err   = sym_valid & err;

endmodule

// File: tb/tb_press_sequencer.sv
// Directed bench for press_sequencer: stimulus pushes expected symbols into a
// queue and a negedge monitor pops and compares them at each handshake.
module tb_press_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       sym_ready = 1'b1;
  logic       sym_valid;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       sym_err;
  logic       elem_short;
  logic       elem_long;
  logic       btn_db;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] bits;
    logic [2:0] len;
    logic       err;
    int         shorts;
    int         longs;
  } exp_t;

  exp_t exp_q[$];
  int   n_short = 0;
  int   n_long  = 0;

  press_sequencer #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3),
    .SHORT_MAX (3),
    .LONG_MIN  (6),
    .GAP_TICKS (8),
    .MAX_LEN   (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid),
    .sym_bits  (sym_bits),
    .sym_len   (sym_len),
    .sym_err   (sym_err),
    .elem_short(elem_short),
    .elem_long (elem_long),
    .btn_db    (btn_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Button held for 4*ticks+2 cycles measures exactly `ticks` duration ticks
  task automatic press(input int ticks);
    button = 1'b1;
    repeat (4 * ticks + 2) step();
    button = 1'b0;
  endtask

  task automatic gap(input int ticks);
    repeat (4 * ticks + 2) step();
  endtask

  task automatic expect_sym(input logic [4:0] b, input logic [2:0] l, input logic e,
                            input int s, input int lg);
    exp_t x;
    x.bits = b; x.len = l; x.err = e; x.shorts = s; x.longs = lg;
    exp_q.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(sym_valid), 0);
    check({tag, "_bits"},  int'(sym_bits), 0);
    check({tag, "_len"},   int'(sym_len), 0);
    check({tag, "_err"},   int'(sym_err), 0);
    check({tag, "_elem"},  int'({elem_short, elem_long}), 0);
    check({tag, "_btn_db"}, int'(btn_db), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      n_short = 0;
      n_long  = 0;
    end else begin
      if (elem_short) n_short++;
      if (elem_long)  n_long++;
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", 1, 0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("sym_len",    int'(sym_len),  int'(x.len));
          check("sym_bits",   int'(sym_bits), int'(x.bits));
          check("sym_err",    int'(sym_err),  int'(x.err));
          check("elem_short_count", n_short, x.shorts);
          check("elem_long_count",  n_long,  x.longs);
        end
        n_short = 0;
        n_long  = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       ok;
    logic [4:0] snap_bits;
    logic [2:0] snap_len;
    logic       snap_err;
    int         n;

    #1;
    check_all_zero("reset");
    step();
    step();
    reset = 1'b1;
    step();

    // Single short press
    expect_sym(5'b00000, 3'd1, 1'b0, 1, 0);
    press(2);
    gap(15);

    // Long, short, long
    expect_sym(5'b00101, 3'd3, 1'b0, 1, 2);
    press(8); gap(3);
    press(2); gap(3);
    press(8);
    gap(15);

    // Ambiguous duration
    expect_sym(5'b00000, 3'd0, 1'b1, 0, 0);
    press(4);
    gap(15);

    // Six shorts overflow
    expect_sym(5'b00000, 3'd5, 1'b1, 6, 0);
    for (int i = 0; i < 6; i++) begin
      press(2);
      gap(3);
    end
    gap(15);

    // Bouncing button never settles
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      button = (i % 2 == 0);
      repeat (2) begin
        step();
        if (btn_db !== 1'b0 || sym_valid !== 1'b0) ok = 1'b0;
      end
    end
    button = 1'b0;
    repeat (8) begin
      step();
      if (btn_db !== 1'b0 || sym_valid !== 1'b0) ok = 1'b0;
    end
    check("bounce_ignored", int'(ok), 1);
    expect_sym(5'b00000, 3'd1, 1'b0, 1, 0);
    press(2);
    gap(15);

    // Stalled consumer
    sym_ready = 1'b0;
    expect_sym(5'b00001, 3'd1, 1'b0, 0, 1);
    press(8);
    n = 0;
    while (!sym_valid && n < 200) begin
      step();
      n++;
    end
    check("emit_timeout", int'(n < 200), 1);
    snap_bits = sym_bits;
    snap_len  = sym_len;
    snap_err  = sym_err;
    check("stall_len_snapshot", int'(snap_len), 1);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 3)  button = 1'b1;
      if (i == 13) button = 1'b0;
      step();
      if (sym_valid !== 1'b1 || sym_bits !== snap_bits || sym_len !== snap_len ||
          sym_err !== snap_err || elem_short !== 1'b0 || elem_long !== 1'b0)
        ok = 1'b0;
    end
    check("stall_stable", int'(ok), 1);
    sym_ready = 1'b1;
    step();
    check("valid_drop_after_accept", int'(sym_valid), 0);
    gap(15);

    // Reset in the middle of a press
    button = 1'b1;
    repeat (10) step();
    check("pre_reset_btn_db", int'(btn_db), 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    step();
    button = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    expect_sym(5'b00000, 3'd1, 1'b0, 1, 0);
    press(2);
    gap(15);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_sequencer.md
PRESS_SEQUENCER -- requirements
Module: press_sequencer

Interface
REQ-001 Parameter TICK_DIV, 6510, clk cycles per duration tick (about 3840 ticks/s at 25 MHz).
REQ-002 Parameter DEB_CYCLES, 250000, consecutive stable cycles needed to accept a button level change.
REQ-003 Parameter SHORT_MAX, 3840, maximum tick count classified as a short element.
REQ-004 Parameter LONG_MIN, 4800, minimum tick count classified as a long element.
REQ-005 Parameter GAP_TICKS, 7680, released-button ticks that terminate a symbol.
REQ-006 Parameter MAX_LEN, 5, maximum elements per symbol (1..5).
REQ-007 clk  input  1  single system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-009 button  input  1  raw asynchronous push-button, 1 = pressed.
REQ-010 sym_ready  input  1  consumer accepts the presented symbol.
REQ-011 sym_valid  output  1  symbol present on sym_bits/sym_len/sym_err.
REQ-012 sym_bits  output  5  elements, first element in bit 0, 1 = long, 0 = short; bits at or above sym_len are 0.
REQ-013 sym_len  output  3  number of valid elements, 0..MAX_LEN.
REQ-014 sym_err  output  1  symbol held an ambiguous press or overflowed.
REQ-015 elem_short, elem_long  output  1 each  one-cycle pulses at classification of a short/long press.
REQ-016 btn_db  output  1  debounced button level.

Function
REQ-017 button passes a 2-flop synchronizer; btn_db changes only after the synchronized level differs from btn_db for DEB_CYCLES consecutive cycles, and any bounce restarts the count.
REQ-018 The prescaler counts 0..TICK_DIV-1 and emits a tick on wrap; it clears on every btn_db edge.
REQ-019 The 14-bit duration counter and the gap counter saturate at 16383 and never wrap.
REQ-020 FSM states: IDLE, PRESS, GAP, EMIT; reset state IDLE.
REQ-021 IDLE: a btn_db rising edge moves to PRESS and clears the duration counter; otherwise stay.
REQ-022 PRESS: count ticks; a btn_db falling edge classifies the duration and moves to GAP, clearing the gap counter.
REQ-023 Classification: dur <= SHORT_MAX gives short; dur >= LONG_MIN gives long; otherwise ambiguous, which sets the error flag and appends nothing.
REQ-024 A short/long element is appended at index len and len increments, with the elem_short/elem_long pulse in the same cycle as the append.
REQ-025 If len == MAX_LEN, a classified element is discarded, the error flag is set, and the element pulse still fires.
REQ-026 GAP: a btn_db rising edge before the gap count reaches GAP_TICKS moves to PRESS and clears duration.
REQ-027 GAP: when the gap count reaches GAP_TICKS, go to EMIT if len > 0 or the error flag is set, else to IDLE.
REQ-028 EMIT: sym_valid = 1, with outputs stable until a cycle where sym_ready = 1.
REQ-029 On that sym_ready cycle: clear len, bits and error, deassert sym_valid on the next cycle, and go to IDLE.
REQ-030 sym_ready while not in EMIT has no effect; button activity during EMIT is ignored except for btn_db tracking.
REQ-031 Leaving EMIT with the button held requires a fresh btn_db rising edge to start a press.
REQ-032 Latency: sym_valid rises on the cycle after the gap count reaches GAP_TICKS.

Reset
REQ-033 reset low immediately forces IDLE and clears every output and register (sym_valid, sym_bits, sym_len, sym_err, elem pulses, btn_db, all counters, synchronizer).
REQ-034 Reset mid-PRESS, mid-GAP or during EMIT discards any partial or pending symbol; release starts in IDLE with btn_db = 0.

Verification
Bench parameters: TICK_DIV=4, DEB_CYCLES=3, SHORT_MAX=3, LONG_MIN=6, GAP_TICKS=8, MAX_LEN=5; sym_ready held 1 unless stated.
REQ-035 Press 2 ticks, release -> elem_short pulse; after 8 gap ticks, sym_valid=1, sym_len=1, sym_bits=00000, sym_err=0.
REQ-036 Press long (8 ticks), short (2), long (8), each gap 3 ticks -> sym_len=3, sym_bits=00101, sym_err=0.
REQ-037 Press 4 ticks (ambiguous), then gap -> no element pulse; sym_valid with sym_len=0, sym_err=1.
REQ-038 Six short presses -> sym_len=5, sym_bits=00000, sym_err=1, six elem_short pulses.
REQ-039 Button bouncing 1-0-1 every 2 cycles for 20 cycles -> btn_db stays 0 and the FSM stays in IDLE.
REQ-040 sym_ready=0 for 50 cycles in EMIT -> outputs stable and a press is ignored; sym_ready=1 -> sym_valid=0 next cycle, FSM in IDLE.
REQ-041 reset low mid-PRESS -> all outputs 0 immediately; after release, a short press yields a fresh sym_len=1 symbol.
